// File: rtl/axis_weights_dma_scheduler_if.sv
// ---------------------------------------------------------------------------
// axis_weights_dma_scheduler_if
//
// Purpose: bundles the three stream channels of the weight DMA scheduler:
//   - descriptor channel (config path -> scheduler)
//   - DataMover MM2S command channel (scheduler -> DataMover)
//   - DataMover MM2S status channel (DataMover -> scheduler)
//
// Signals:
//   s_desc_tvalid / s_desc_tready   descriptor handshake
//   s_desc_addr   [ADDR_WIDTH]      weight block base byte address
//   s_desc_btt    [BTT_WIDTH]       bytes per rotator buffer fill
//   s_desc_it_1   [BITS_IT]         repeat count minus one
//   s_desc_last                     final descriptor of the run
//   m_cmd_tvalid / m_cmd_tready     command handshake
//   m_cmd_tdata   [72]              DataMover command word
//   s_sts_tvalid / s_sts_tready     status handshake
//   s_sts_tdata   [8]               DataMover status beat
//
// Modports:
//   slave  - the scheduler side
//   master - the environment side (config path + DataMover)
// ---------------------------------------------------------------------------
interface axis_weights_dma_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BTT_WIDTH  = 23,
    parameter int BITS_IT    = 10
);
    logic                  s_desc_tvalid;
    logic                  s_desc_tready;
    logic [ADDR_WIDTH-1:0] s_desc_addr;
    logic [BTT_WIDTH-1:0]  s_desc_btt;
    logic [BITS_IT-1:0]    s_desc_it_1;
    logic                  s_desc_last;

    logic                  m_cmd_tvalid;
    logic                  m_cmd_tready;
    logic [71:0]           m_cmd_tdata;

    logic                  s_sts_tvalid;
    logic                  s_sts_tready;
    logic [7:0]            s_sts_tdata;

    modport slave (
        input  s_desc_tvalid, s_desc_addr, s_desc_btt, s_desc_it_1, s_desc_last,
        output s_desc_tready,
        output m_cmd_tvalid, m_cmd_tdata,
        input  m_cmd_tready,
        input  s_sts_tvalid, s_sts_tdata,
        output s_sts_tready
    );

    modport master (
        output s_desc_tvalid, s_desc_addr, s_desc_btt, s_desc_it_1, s_desc_last,
        input  s_desc_tready,
        input  m_cmd_tvalid, m_cmd_tdata,
        output m_cmd_tready,
        output s_sts_tvalid, s_sts_tdata,
        input  s_sts_tready
    );
endinterface

// File: rtl/axis_weights_dma_scheduler.sv
// ---------------------------------------------------------------------------
// axis_weights_dma_scheduler
//
// Purpose: sequences weight loading into the double-buffered weight rotator.
// Each accepted descriptor is expanded into (it_1 + 1) AXI DataMover MM2S
// commands, all fetching the same weight block. A credit counter limits the
// number of fills in flight to BUFFERS; a credit is returned each time the
// rotator reports that it has finished reading one buffer (rot_last).
//
// Optional feature (macro WSCHED_STATUS_CHECK_EN): DataMover status beats
// are checked for tag order and OKAY/error bits. Without the macro the
// status channel is always ready and its beats are discarded.
//
// Ports:
//   aclk          clock
//   rst           asynchronous active-high reset
//   bus           descriptor / command / status channels (slave modport)
//   rot_last      one-cycle pulse, rotator finished consuming a buffer
//   outstanding   fills issued but not yet consumed
//   busy          a run is active (descriptor accepted, done not yet given)
//   done          one-cycle pulse at the end of a run
//   error         sticky {underflow, tag_err, sts_err}
// ---------------------------------------------------------------------------
module axis_weights_dma_scheduler #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  BTT_WIDTH  = 23,
    parameter int  IT_MAX     = 1024,
    parameter int  BUFFERS    = 2,
    localparam int BITS_IT    = $clog2(IT_MAX),
    localparam int BITS_CR    = $clog2(BUFFERS + 1)
) (
    input  logic                       aclk,
    input  logic                       rst,
    axis_weights_dma_scheduler_if.slave bus,
    input  logic                       rot_last,
    output logic [BITS_CR-1:0]         outstanding,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 error
);

    localparam logic [BITS_CR-1:0] CREDITS = BITS_CR'(BUFFERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  run_q;
    logic [3:0]            tag_q;
    logic [BITS_IT-1:0]    it_cnt_q;
    logic [BITS_CR-1:0]    out_q;
    logic [BITS_CR-1:0]    out_d;
    logic                  underflow_q;
    logic                  uf_set_d;
    logic                  tag_err;
    logic                  sts_err;

    // Descriptor fields; held for the whole descriptor, no reset needed.
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BTT_WIDTH-1:0]  btt_q;
    logic [BITS_IT-1:0]    it_1_q;
    logic                  last_q;

    logic                  desc_hs;
    logic                  cmd_valid;
    logic                  cmd_hs;

    assign desc_hs   = (state_q == S_IDLE) && bus.s_desc_tvalid;
    // Valid is gated by the credit count, so outstanding can never pass BUFFERS.
    assign cmd_valid = (state_q == S_ISSUE) && (out_q < CREDITS);
    assign cmd_hs    = cmd_valid && bus.m_cmd_tready;

    // Credit accounting: an issue and a consume in the same cycle cancel.
    // A consume with nothing in flight is an underflow; the count holds at 0.
    always_comb begin
        out_d    = out_q;
        uf_set_d = 1'b0;
        if (cmd_hs && !rot_last) begin
            out_d = out_q + BITS_CR'(1);
        end else if (!cmd_hs && rot_last) begin
            if (out_q == '0) begin
                uf_set_d = 1'b1;
            end else begin
                out_d = out_q - BITS_CR'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            tag_q       <= '0;
            it_cnt_q    <= '0;
            out_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            out_q <= out_d;
            if (uf_set_d) begin
                underflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (desc_hs) begin
                        it_cnt_q <= '0;
                        run_q    <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_hs) begin
                        tag_q <= tag_q + 4'd1;
                        if (it_cnt_q == it_1_q) begin
                            // Non-last descriptors return to idle with the run
                            // still open so busy stays asserted.
                            state_q <= last_q ? S_DRAIN : S_IDLE;
                        end else begin
                            it_cnt_q <= it_cnt_q + BITS_IT'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_q == '0) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    run_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (desc_hs) begin
            addr_q <= bus.s_desc_addr;
            btt_q  <= bus.s_desc_btt;
            it_1_q <= bus.s_desc_it_1;
            last_q <= bus.s_desc_last;
        end
    end

`ifdef WSCHED_STATUS_CHECK_EN
    logic [3:0] exp_tag_q;
    logic       tag_err_q;
    logic       sts_err_q;

    // Status beats come back in command order, so the expected tag simply
    // counts beats. OKAY requires bit 7 set and the error bits [6:4] clear.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            exp_tag_q <= '0;
            tag_err_q <= 1'b0;
            sts_err_q <= 1'b0;
        end else if (bus.s_sts_tvalid) begin
            if (bus.s_sts_tdata[3:0] != exp_tag_q) begin
                tag_err_q <= 1'b1;
            end
            if (!bus.s_sts_tdata[7] || (|bus.s_sts_tdata[6:4])) begin
                sts_err_q <= 1'b1;
            end
            exp_tag_q <= exp_tag_q + 4'd1;
        end
    end

    assign tag_err = tag_err_q;
    assign sts_err = sts_err_q;
`else
    logic sts_unused;

    assign sts_unused = ^{bus.s_sts_tvalid, bus.s_sts_tdata};
    assign tag_err    = 1'b0;
    assign sts_err    = 1'b0;
`endif

    assign bus.s_sts_tready  = 1'b1;
    assign bus.s_desc_tready = (state_q == S_IDLE);
    assign bus.m_cmd_tvalid  = cmd_valid;
    // Command word: BTT, INCR, EOF, address, tag. DRR/DSA/cache fields are 0.
    assign bus.m_cmd_tdata   = {4'b0000, tag_q, 32'(addr_q),
                                1'b0, 1'b1, 6'b000000, 1'b1, 23'(btt_q)};

    assign outstanding = out_q;
    assign busy        = run_q;
    assign done        = (state_q == S_DONE);
    assign error       = {underflow_q, tag_err, sts_err};

endmodule

// File: tb/tb_axis_weights_dma_scheduler.sv
module tb_axis_weights_dma_scheduler;

    logic       aclk = 1'b0;
    logic       rst;
    logic       rot_last;
    logic [1:0] outstanding;
    logic       busy;
    logic       done;
    logic [2:0] error;

    int n_vec  = 0;
    int n_miss = 0;

    logic [71:0] cmd_q[$];
    int          done_cnt = 0;

    axis_weights_dma_scheduler_if #(.ADDR_WIDTH(32), .BTT_WIDTH(23), .BITS_IT(10)) bus ();

    axis_weights_dma_scheduler #(
        .ADDR_WIDTH(32),
        .BTT_WIDTH (23),
        .IT_MAX    (1024),
        .BUFFERS   (2)
    ) dut (
        .aclk       (aclk),
        .rst        (rst),
        .bus        (bus),
        .rot_last   (rot_last),
        .outstanding(outstanding),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 aclk = ~aclk;

    // Record every command handshake and every done cycle.
    always @(posedge aclk) begin
        if (bus.m_cmd_tvalid && bus.m_cmd_tready) begin
            cmd_q.push_back(bus.m_cmd_tdata);
        end
        if (done) begin
            done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        rst                = 1'b1;
        rot_last           = 1'b0;
        bus.s_desc_tvalid  = 1'b0;
        bus.m_cmd_tready   = 1'b0;
        bus.s_sts_tvalid   = 1'b0;
        bus.s_sts_tdata    = 8'h00;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic send_desc(input logic [31:0] addr, input logic [22:0] btt,
                             input logic [9:0] it_1, input logic last);
        bus.s_desc_tvalid = 1'b1;
        bus.s_desc_addr   = addr;
        bus.s_desc_btt    = btt;
        bus.s_desc_it_1   = it_1;
        bus.s_desc_last   = last;
        tick();
        bus.s_desc_tvalid = 1'b0;
    endtask

    task automatic pulse_rot(input int gap);
        rot_last = 1'b1;
        tick();
        rot_last = 1'b0;
        ticks(gap);
    endtask

    initial begin
        int base;
        int dbase;
        logic [71:0] cmd;

        rst               = 1'b1;
        rot_last          = 1'b0;
        bus.s_desc_tvalid = 1'b0;
        bus.s_desc_addr   = '0;
        bus.s_desc_btt    = '0;
        bus.s_desc_it_1   = '0;
        bus.s_desc_last   = 1'b0;
        bus.m_cmd_tready  = 1'b0;
        bus.s_sts_tvalid  = 1'b0;
        bus.s_sts_tdata   = 8'h00;
        ticks(2);

        // Reset state
        check_eq("rst_desc_tready", bus.s_desc_tready, 1);
        check_eq("rst_cmd_tvalid",  bus.m_cmd_tvalid, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_busy",        busy, 0);
        check_eq("rst_done",        done, 0);
        check_eq("rst_error",       error, 0);
        rst = 1'b0;

        // Credit limit: 5 fills of one block, only 2 in flight
        base  = cmd_q.size();
        dbase = done_cnt;
        bus.m_cmd_tready = 1'b1;
        send_desc(32'h1000_0000, 23'h240, 10'd4, 1'b1);
        ticks(6);
        check_eq("cl_cmd_count",   cmd_q.size() - base, 2);
        check_eq("cl_outstanding", outstanding, 2);
        check_eq("cl_tvalid_held", bus.m_cmd_tvalid, 0);
        check_eq("cl_busy",        busy, 1);
        cmd = cmd_q[base];
        check_eq("cl_cmd0_word", cmd, 72'h00_1000_0000_4080_0240);
        cmd = cmd_q[base + 1];
        check_eq("cl_cmd1_tag",  cmd[67:64], 1);
        for (int i = 0; i < 3; i++) pulse_rot(2);
        check_eq("cl_cmd_count5", cmd_q.size() - base, 5);
        for (int i = 2; i < 5; i++) begin
            cmd = cmd_q[base + i];
            check_eq("cl_tag_seq", cmd[67:64], i);
        end
        cmd = cmd_q[base + 3];
        check_eq("cl_cmd3_word", cmd, 72'h03_1000_0000_4080_0240);
        check_eq("cl_outstanding2", outstanding, 2);
        check_eq("cl_done_early",   done_cnt - dbase, 0);
        pulse_rot(2);
        pulse_rot(2);
        ticks(3);
        check_eq("cl_done_once",     done_cnt - dbase, 1);
        check_eq("cl_outstanding0",  outstanding, 0);
        check_eq("cl_busy_end",      busy, 0);
        check_eq("cl_error",         error, 0);

        // Command encoding and simultaneous issue + consume
        do_reset();
        base  = cmd_q.size();
        dbase = done_cnt;
        send_desc(32'hDEAD_BEEC, 23'h7F_FFFF, 10'd1, 1'b1);
        tick();
        check_eq("enc_tvalid", bus.m_cmd_tvalid, 1);
        check_eq("enc_word",   bus.m_cmd_tdata, 72'h00_DEAD_BEEC_40FF_FFFF);
        tick();
        check_eq("enc_stable", bus.m_cmd_tdata, 72'h00_DEAD_BEEC_40FF_FFFF);
        bus.m_cmd_tready = 1'b1;
        tick();
        check_eq("sim_out_before", outstanding, 1);
        rot_last = 1'b1;
        tick();
        rot_last = 1'b0;
        bus.m_cmd_tready = 1'b0;
        check_eq("sim_out_after", outstanding, 1);
        check_eq("sim_cmd_count", cmd_q.size() - base, 2);
        cmd = cmd_q[base + 1];
        check_eq("sim_tag_inc", cmd[67:64], 1);
        check_eq("sim_error",   error, 0);
        pulse_rot(4);
        check_eq("sim_done", done_cnt - dbase, 1);

        // Underflow while idle
        do_reset();
        pulse_rot(0);
        check_eq("uf_error",       error, 3'b100);
        check_eq("uf_outstanding", outstanding, 0);
        ticks(3);
        check_eq("uf_sticky",      error, 3'b100);
        do_reset();
        check_eq("uf_cleared",     error, 0);

        // Multi-descriptor run: A (1 fill, not last) then B (2 fills, last)
        base  = cmd_q.size();
        dbase = done_cnt;
        bus.m_cmd_tready = 1'b1;
        send_desc(32'h0000_2000, 23'h10, 10'd0, 1'b0);
        ticks(3);
        check_eq("md_gap_busy",   busy, 1);
        check_eq("md_gap_ready",  bus.s_desc_tready, 1);
        check_eq("md_gap_count",  cmd_q.size() - base, 1);
        send_desc(32'h0000_3000, 23'h20, 10'd1, 1'b1);
        ticks(3);
        check_eq("md_b_blocked",  cmd_q.size() - base, 2);
        pulse_rot(2);
        pulse_rot(2);
        check_eq("md_cmd_count",  cmd_q.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            cmd = cmd_q[base + i];
            check_eq("md_tag_seq", cmd[67:64], i);
        end
        check_eq("md_not_done",   done_cnt - dbase, 0);
        check_eq("md_busy_drain", busy, 1);
        pulse_rot(4);
        check_eq("md_done",       done_cnt - dbase, 1);
        check_eq("md_busy_end",   busy, 0);
        bus.m_cmd_tready = 1'b0;

        // Status channel
        do_reset();
        check_eq("sts_tready", bus.s_sts_tready, 1);
`ifdef WSCHED_STATUS_CHECK_EN
        bus.s_sts_tvalid = 1'b1;
        bus.s_sts_tdata  = 8'h80;
        tick();
        check_eq("sts_ok",      error, 3'b000);
        bus.s_sts_tdata  = 8'hC1;
        tick();
        check_eq("sts_err_bit", error, 3'b001);
        bus.s_sts_tdata  = 8'h83;
        tick();
        bus.s_sts_tvalid = 1'b0;
        check_eq("sts_tag_err", error, 3'b011);
`else
        bus.s_sts_tvalid = 1'b1;
        bus.s_sts_tdata  = 8'hC1;
        tick();
        bus.s_sts_tdata  = 8'h03;
        tick();
        bus.s_sts_tvalid = 1'b0;
        check_eq("sts_ignored", error, 3'b000);
`endif

        // Reset mid-run
        do_reset();
        send_desc(32'h0000_4000, 23'h40, 10'd3, 1'b1);
        tick();
        check_eq("mr_tvalid_pre", bus.m_cmd_tvalid, 1);
        bus.m_cmd_tready = 1'b1;
        tick();
        bus.m_cmd_tready = 1'b0;
        check_eq("mr_out_pre",    outstanding, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mr_tvalid_async", bus.m_cmd_tvalid, 0);
        check_eq("mr_out_async",    outstanding, 0);
        check_eq("mr_busy_async",   busy, 0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("mr_desc_tready",  bus.s_desc_tready, 1);
        check_eq("mr_tvalid_after", bus.m_cmd_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axis_weights_dma_scheduler.md
Name: axis_weights_dma_scheduler

Overview:
- Sequences weight loading into the double-buffered weight rotator.
- Accepts weight-block descriptors from the config path and issues AXI DataMover MM2S commands, one per rotator buffer fill.
- Credit-based flow control keeps at most BUFFERS fills in flight; a credit returns when the rotator signals end of a buffer read.
- Optionally checks DataMover status beats.

Parameters:
- ADDR_WIDTH, 32, DDR byte-address width.
- BTT_WIDTH, 23, bytes-to-transfer field width (DataMover limit).
- IT_MAX, 1024, maximum repeats of one descriptor.
- BUFFERS, 2, rotator buffers, i.e. the credit count.
- Derived: BITS_IT = $clog2(IT_MAX), BITS_CR = $clog2(BUFFERS+1).

Ports:
- aclk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_desc_tvalid  in  1  descriptor valid.
- s_desc_tready  out  1  descriptor ready.
- s_desc_addr  in  ADDR_WIDTH  weight block base address.
- s_desc_btt  in  BTT_WIDTH  bytes per fill.
- s_desc_it_1  in  BITS_IT  repeats minus 1.
- s_desc_last  in  1  final descriptor of the run.
- m_cmd_tvalid  out  1  DataMover command valid.
- m_cmd_tready  in  1  DataMover command ready.
- m_cmd_tdata  out  72  DataMover command.
- s_sts_tvalid  in  1  status valid.
- s_sts_tready  out  1  status ready.
- s_sts_tdata  in  8  DataMover status.
- rot_last  in  1  one-cycle pulse: rotator m_axis_tlast handshake (buffer consumed).
- outstanding  out  BITS_CR  fills issued but not yet consumed.
- busy  out  1  high in any state except S_IDLE with no run active.
- done  out  1  one-cycle pulse at end of run.
- error  out  3  sticky: {underflow, tag_err, sts_err}.

Behaviour:
- Reset (async assert on rst, sync deassert by the integrator):
  - State S_IDLE; outstanding, tag, exp_tag, iteration counter and error all 0.
  - m_cmd_tvalid=0, done=0, busy=0.
  - s_desc_tready=1.
- Any rst mid-operation aborts immediately and drops m_cmd_tvalid. No pending command is preserved.
- S_IDLE:
  - s_desc_tready=1.
  - On descriptor handshake, latch addr/btt/it_1/last, clear the iteration counter, go to S_ISSUE.
- S_ISSUE:
  - s_desc_tready=0; m_cmd_tvalid = (outstanding < BUFFERS).
  - m_cmd_tdata is registered-stable while valid: [22:0]=btt, zero-extended if BTT_WIDTH<23. [23]=1 (INCR). [29:24]=0. [30]=1 (EOF). [31]=0. [63:32]=addr. [67:64]=tag. [71:68]=0.
  - On command handshake: tag++ (mod 16) and outstanding++.
  - If iteration counter == it_1: go to S_DRAIN if latched last, else S_IDLE. Otherwise iteration counter++.
  - Address is not advanced; each repeat re-fetches the same block.
- S_DRAIN: m_cmd_tvalid=0; when outstanding==0, go to S_DONE.
- S_DONE: done=1 for exactly one cycle, then S_IDLE. A new run may start the next cycle.
- Credit counter:
  - Command handshake and rot_last in the same cycle: outstanding unchanged.
  - rot_last with outstanding==0: hold at 0, set error[2].
  - Increment never exceeds BUFFERS, because valid is gated.
- Latency:
  - Descriptor handshake to first m_cmd_tvalid: 1 cycle.
  - A credit freed by rot_last in cycle N enables m_cmd_tvalid in cycle N+1.
  - Consecutive commands can issue back-to-back while credits remain.
- busy=1 from descriptor accept until done. busy also stays 1 in S_IDLE between non-last descriptors.
- Descriptors with it_1=0 issue exactly one command.

Optional Feature:
- Macro: WSCHED_STATUS_CHECK_EN.
- Defined:
  - s_sts_tready=1.
  - Each status beat is compared against exp_tag: s_sts_tdata[3:0] != exp_tag sets error[1].
  - s_sts_tdata[7]==0, or any of bits [6:4] set, sets error[0].
  - exp_tag increments per beat.
- Not defined:
  - s_sts_tready tied 1; status beats are discarded.
  - error[1:0] tied 0.
  - No exp_tag register is synthesised.

Test Plan:
- Credit limit: one descriptor (addr=0x1000_0000, btt=0x240, it_1=4, last=1), m_cmd_tready=1, no rot_last.
  - Exactly 2 commands issue, tags 0 and 1, outstanding=2, m_cmd_tvalid stays 0.
  - Then 3 rot_last pulses, each spaced 3 cycles, release commands 3 and 4 and then 5 (tags 2, 3, 4).
  - After two more rot_last pulses, done pulses once and outstanding=0.
- Command encoding: btt=0x7FFFFF, addr=0xDEAD_BEEC → m_cmd_tdata == 72'h0_0_DEADBEEC_40_FFFFFF | (1<<23), tag field 0.
- Simultaneous events: with outstanding=1, assert m_cmd_tready and rot_last in the same cycle → outstanding remains 1, tag increments.
- Underflow: rot_last pulse while idle with outstanding=0 → error=3'b100, outstanding stays 0, sticky until rst.
- Multi-descriptor: descriptors A (it_1=0, last=0) then B (it_1=1, last=1) with 2 rot_last pulses.
  - 3 commands total, tags 0 to 2.
  - done only after B drains; busy stays high through the gap between A and B.
- Status check (WSCHED_STATUS_CHECK_EN):
  - Return status 8'h80 tag 0 → no error.
  - Then 8'hC1 → error[0]=1.
  - Then 8'h83 when exp_tag=2 → error[1]=1.
- Reset mid-run: assert rst while m_cmd_tvalid=1 → m_cmd_tvalid=0 immediately (asynchronous), outstanding=0, state S_IDLE, s_desc_tready=1 after release.
